// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scanner: segment bit positions,
// blank pattern and the hex-to-segment decode table (bit order abc_defg).
package sevenseg_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b111_1110;
            4'h1:    seg = 7'b011_0000;
            4'h2:    seg = 7'b110_1101;
            4'h3:    seg = 7'b111_1001;
            4'h4:    seg = 7'b011_0011;
            4'h5:    seg = 7'b101_1011;
            4'h6:    seg = 7'b101_1111;
            4'h7:    seg = 7'b111_0000;
            4'h8:    seg = 7'b111_1111;
            4'h9:    seg = 7'b111_0011;
            4'hA:    seg = 7'b111_0111;
            4'hB:    seg = 7'b001_1111;
            4'hC:    seg = 7'b100_1110;
            4'hD:    seg = 7'b011_1101;
            4'hE:    seg = 7'b100_1111;
            default: seg = 7'b100_0111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment driver with latched shadow data.
// Optional leading-zero suppression: define SEVENSEG_ZERO_SUPPRESS_EN.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int DIV     = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   data,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   enable,
    output logic [6:0]             segments,
    output logic                   dp,
    output logic [NDIGITS-1:0]     anode
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int PW = $clog2(DIV);

    logic [PW-1:0]          pcnt_reg, pcnt_next;
    logic [IW-1:0]          idx_reg, idx_next;
    logic [4*NDIGITS-1:0]   dshadow_reg;
    logic [NDIGITS-1:0]     dpshadow_reg;
    logic [6:0]             seg_reg, seg_next;
    logic                   dp_reg, dp_next;
    logic [NDIGITS-1:0]     anode_reg, anode_next;
    logic                   tick;

    logic [3:0]             digit_arr [NDIGITS];
    logic [NDIGITS-1:0]     suppress;

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = dshadow_reg[4*gi +: 4];
`ifdef SEVENSEG_ZERO_SUPPRESS_EN
            // A digit blanks only if it and every more-significant digit are zero.
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = ~|dshadow_reg[4*NDIGITS-1 : 4*gi];
            end
`else
            assign suppress[gi] = 1'b0;
`endif
        end
    endgenerate

    assign tick = (pcnt_reg == PW'(DIV - 1));

    always_comb begin
        pcnt_next  = pcnt_reg + PW'(1);
        idx_next   = idx_reg;
        seg_next   = SEG_BLANK;
        dp_next    = 1'b0;
        anode_next = '0;
        if (tick) begin
            pcnt_next = '0;
            idx_next  = (idx_reg == IW'(NDIGITS - 1)) ? '0 : idx_reg + IW'(1);
        end
        // Outputs reflect the current (pre-advance) index, so they lag idx by one edge.
        if (enable) begin
            anode_next = NDIGITS'(1) << idx_reg;
            seg_next   = suppress[idx_reg] ? SEG_BLANK : hex_to_seg(digit_arr[idx_reg]);
            dp_next    = dpshadow_reg[idx_reg];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_reg     <= '0;
            idx_reg      <= '0;
            dshadow_reg  <= '0;
            dpshadow_reg <= '0;
            seg_reg      <= SEG_BLANK;
            dp_reg       <= 1'b0;
            anode_reg    <= '0;
        end else begin
            pcnt_reg  <= pcnt_next;
            idx_reg   <= idx_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
            anode_reg <= anode_next;
            if (load) begin
                dshadow_reg  <= data;
                dpshadow_reg <= dp_in;
            end
        end
    end

    assign segments = seg_reg;
    assign dp       = dp_reg;
    assign anode    = anode_reg;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan (NDIGITS=4, DIV=4); the reference model
// follows SEVENSEG_ZERO_SUPPRESS_EN the same way the design build does.
module tb_sevenseg_scan;

    localparam int ND  = 4;
    localparam int DV  = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           load = 1'b0;
    logic [15:0]    data = '0;
    logic [3:0]     dp_in = '0;
    logic           enable = 1'b1;
    logic [6:0]     segments;
    logic           dp;
    logic [3:0]     anode;

    sevenseg_scan #(.NDIGITS(ND), .DIV(DV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .data     (data),
        .dp_in    (dp_in),
        .enable   (enable),
        .segments (segments),
        .dp       (dp),
        .anode    (anode)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          fails = 0;
    logic [6:0]  seg_tbl [16];
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;
    int          n = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock of the reference: the digit shown is floor(n/DIV) mod NDIGITS.
    task automatic cycle(input string tag);
        int         i;
        logic [6:0] es;
        logic [3:0] ea;
        logic       ed;
        i  = (n / DV) % ND;
        es = 7'b0;
        ea = 4'b0;
        ed = 1'b0;
        if (enable) begin
            ea = 4'(1 << i);
            es = seg_tbl[(m_data >> (4 * i)) & 16'hF];
`ifdef SEVENSEG_ZERO_SUPPRESS_EN
            if (i > 0 && (m_data >> (4 * i)) == 0) es = 7'b0;
`endif
            ed = m_dp[i];
        end
        @(posedge clk);
        #1;
        chk({tag, "_anode"}, {4'b0, anode}, {4'b0, ea});
        chk({tag, "_seg"}, {1'b0, segments}, {1'b0, es});
        chk({tag, "_dp"}, {7'b0, dp}, {7'b0, ed});
        if (load) begin
            m_data = data;
            m_dp   = dp_in;
        end
        n++;
    endtask

    task automatic run(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) cycle(tag);
    endtask

    task automatic advance_until(input int modv, input int target);
        int k;
        k = 0;
        while ((n % modv) != target && k < 64) begin
            cycle("adv");
            k++;
        end
        total++;
        if ((n % modv) != target) begin
            fails++;
            $error("FAIL advance_timeout observed=%0d expected=%0d", n % modv, target);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_anode"}, {4'b0, anode}, 8'h00);
        chk({tag, "_seg"}, {1'b0, segments}, 8'h00);
        chk({tag, "_dp"}, {7'b0, dp}, 8'h00);
    endtask

    task automatic hold_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_zero(tag);
        end
        @(negedge clk);
        reset_n = 1'b1;
        n      = 0;
        m_data = '0;
        m_dp   = '0;
    endtask

    task automatic load_word(input string tag, input logic [15:0] d, input logic [3:0] p);
        data  = d;
        dp_in = p;
        load  = 1'b1;
        cycle(tag);
        load  = 1'b0;
    endtask

    initial begin
        seg_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        // Reset and release, then a frame and a bit to see the wrap.
        #3 reset_n = 1'b0;
        #1 check_zero("reset");
        hold_reset("reset_hold");
        run("scan", 20);

        // Fixed pattern with a decimal point on digit 2.
        advance_until(16, 15);
        load_word("load1a3f", 16'h1A3F, 4'b0100);
        run("frame1a3f", 16);

        // Asynchronous reset in the middle of digit 2's dwell.
        advance_until(16, 10);
        #2 reset_n = 1'b0;
        #1 check_zero("midreset");
        hold_reset("midreset_hold");
        run("after_reset", 16);

        // Blank for 6 cycles starting at digit 1; scan must keep running.
        load_word("load_en", 16'h8421, 4'b1010);
        advance_until(16, 4);
        enable = 1'b0;
        run("disabled", 6);
        enable = 1'b1;
        run("reenabled", 12);

        // Load on the same edge as a tick.
        advance_until(4, 3);
        load_word("load_tick", 16'hC5E2, 4'b0011);
        run("post_tick", 18);

        // Leading-zero patterns.
        load_word("load0070", 16'h0070, 4'b0000);
        run("zs0070", 16);
        load_word("load0000", 16'h0000, 4'b1000);
        run("zs0000", 16);

        // Random loads, decimal points and enable gating.
        for (int k = 0; k < 400; k++) begin
            data   = 16'($urandom);
            dp_in  = 4'($urandom);
            load   = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 9) != 0);
            cycle("rand");
        end
        load   = 1'b0;
        enable = 1'b1;
        run("tail", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
        $finish;
    end

endmodule
